// File: rtl/qspi_rom_responder.sv
// QSPI flash-ROM responder: decodes host commands (reset-cont, release-PD, WREN,
// WRSR, quad fast read 0xEB with continuous mode) and serves bytes from a backing ROM.
module qspi_rom_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic [3:0]  dq_in,
  output logic [3:0]  dq_out,
  output logic [3:0]  dq_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        qe,
  output logic        cont_mode
);

  typedef enum logic [2:0] {IDLE, CMD, SRWR, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;
  state_t state, state_nxt;

  logic [1:0]      sclk_s, cs_s, sync_vld;
  logic [1:0][3:0] dq_s;
  logic            sclk_q, cs_q, sclk_d, rise, fall, armed;
  logic [3:0]      dq_q;
  logic [4:0]      cnt;
  logic [14:0]     sh;
  logic [23:0]     addr;
  logic [7:0]      sr1, sr2, byte_q, byte_cur, cmd_byte;
  logic            wel, rd_d, hi_nxt, ff_exit;

  assign sclk_q   = sclk_s[1];
  assign cs_q     = cs_s[1];
  assign dq_q     = dq_s[1];
  // cs_n high wins over any sclk edge seen in the same cycle
  assign rise     = sclk_q & ~sclk_d & ~cs_q;
  assign fall     = ~sclk_q & sclk_d & ~cs_q;
  assign cmd_byte = {sh[6:0], dq_q[0]};
  assign ff_exit  = cont_mode && (cnt == 5'd1) && ({addr[3:0], dq_q} == 8'hFF);
  // bypass lets a fall that lands right after the ROM returns use the fresh byte
  assign byte_cur = rd_d ? mem_data : byte_q;
  assign qe       = sr2[1];

  always_comb begin
    state_nxt = state;
    if (cs_q) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:  if (armed) state_nxt = cont_mode ? ADDR : CMD;
        CMD:   if (rise && cnt == 5'd7) begin
                 case (cmd_byte)
                   8'h01:   state_nxt = wel ? SRWR : IGNORE;
                   8'hEB:   state_nxt = qe ? ADDR : IGNORE;
                   default: state_nxt = IGNORE;
                 endcase
               end
        ADDR:  if (rise) begin
                 if (ff_exit)             state_nxt = IGNORE;
                 else if (cnt == 5'd5)    state_nxt = MODE;
               end
        MODE:  if (rise && cnt == 5'd1) state_nxt = DUMMY;
        DUMMY: if (rise && cnt == 5'd3) state_nxt = DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sclk_s    <= '0;
      cs_s      <= '1;
      dq_s      <= '0;
      sync_vld  <= '0;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      addr      <= '0;
      sr1       <= '0;
      sr2       <= '0;
      wel       <= 1'b0;
      cont_mode <= 1'b0;
      byte_q    <= '0;
      rd_d      <= 1'b0;
      hi_nxt    <= 1'b1;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      dq_out    <= '0;
      dq_oe     <= '0;
    end else begin
      state    <= state_nxt;
      sclk_s   <= {sclk_s[0], sclk};
      cs_s     <= {cs_s[0], cs_n};
      dq_s     <= {dq_s[0], dq_in};
      sync_vld <= {sync_vld[0], 1'b1};
      sclk_d   <= sclk_q;
      // a transaction may only start after a genuine cs_n high has been seen
      if (sync_vld[1] && cs_q) armed <= 1'b1;
      mem_rd <= 1'b0;
      rd_d   <= mem_rd;
      if (rd_d) byte_q <= mem_data;
      if (state_nxt != DATA) begin
        dq_out <= '0;
        dq_oe  <= '0;
      end
      if (cs_q) begin
        cnt    <= '0;
        hi_nxt <= 1'b1;
        if (state == SRWR) wel <= 1'b0;
      end else if (rise) begin
        if (state != IDLE && state != DATA && state != IGNORE)
          cnt <= (state_nxt != state) ? 5'd0 : (cnt == 5'd16) ? cnt : cnt + 5'd1;
        case (state)
          CMD: begin
            sh <= {sh[13:0], dq_q[0]};
            if (cnt == 5'd7) begin
              if (cmd_byte == 8'hFF) cont_mode <= 1'b0;
              if (cmd_byte == 8'h06) wel <= 1'b1;
            end
          end
          SRWR: if (cnt < 5'd16) begin
            sh <= {sh[13:0], dq_q[0]};
            // both registers commit together, only once SR2 is complete
            if (cnt == 5'd15) begin
              sr1 <= sh[14:7];
              sr2 <= cmd_byte;
            end
          end
          ADDR: begin
            addr <= {addr[19:0], dq_q};
            if (ff_exit) cont_mode <= 1'b0;
          end
          MODE: begin
            sh[3:0] <= dq_q;
            if (cnt == 5'd1) cont_mode <= (sh[1:0] == 2'b10);
          end
          DUMMY: begin
            hi_nxt <= 1'b1;
            if (cnt == 5'd0) begin
              mem_addr <= addr;
              mem_rd   <= 1'b1;
            end
          end
          DATA: if (hi_nxt) begin
            mem_addr <= mem_addr + 24'd1;
            mem_rd   <= 1'b1;
          end
          default: ;
        endcase
      end else if (fall && state == DATA) begin
        dq_out <= hi_nxt ? byte_cur[7:4] : byte_cur[3:0];
        dq_oe  <= 4'hF;
        hi_nxt <= ~hi_nxt;
      end
    end
  end

endmodule

// File: tb/tb_qspi_rom_responder.sv
// Directed bench for qspi_rom_responder: host bit-bangs sclk/cs_n/dq, ROM is a small model.
module tb_qspi_rom_responder;
  logic        clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1;
  logic [3:0]  dq_in = 4'h0;
  logic [3:0]  dq_out, dq_oe;
  logic [23:0] mem_addr;
  logic        mem_rd, qe, cont_mode;
  logic [7:0]  mem_data = 8'h00;
  logic [23:0] addr_log[$];
  int          n_cmp = 0, n_bad = 0;

  localparam int H = 50;

  always #5 clk = ~clk;

  qspi_rom_responder dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .qe(qe), .cont_mode(cont_mode)
  );

  function automatic logic [7:0] rom_f(input logic [23:0] a);
    case (a)
      24'h000000: return 8'h3C;
      24'h001234: return 8'h11;
      24'h001235: return 8'h22;
      24'h001236: return 8'h33;
      24'hFFFFFF: return 8'hA7;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) if (mem_rd) mem_data <= rom_f(mem_addr);
  always @(negedge clk) if (mem_rd) addr_log.push_back(mem_addr);

  function automatic logic [31:0] log_at(input int i);
    return (i < addr_log.size()) ? {8'h00, addr_log[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    #H sclk = 1'b1;
    #H sclk = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      dq_in = {3'b000, b[i]};
      tick();
    end
  endtask

  task automatic tx_nib(input logic [3:0] n);
    dq_in = n;
    tick();
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_hi();
    #100 cs_n = 1'b1;
    #100;
  endtask

  task automatic cmd1(input logic [7:0] b);
    cs_lo();
    tx_byte(b);
    cs_hi();
  endtask

  task automatic hdr(input logic [23:0] a, input logic [7:0] m);
    for (int i = 5; i >= 0; i--) tx_nib(a[i*4 +: 4]);
    tx_nib(m[7:4]);
    tx_nib(m[3:0]);
    for (int i = 0; i < 4; i++) tx_nib(4'h0);
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    logic [3:0] hi, lo, oe_hi, oe_lo;
    #42 hi = dq_out; oe_hi = dq_oe;
    #8  sclk = 1'b1;
    #50 sclk = 1'b0;
    #42 lo = dq_out; oe_lo = dq_oe;
    #8  sclk = 1'b1;
    #50 sclk = 1'b0;
    chk({tag, ".hi"}, {28'h0, hi}, {28'h0, exp[7:4]});
    chk({tag, ".lo"}, {28'h0, lo}, {28'h0, exp[3:0]});
    chk({tag, ".oe"}, {24'h0, oe_hi, oe_lo}, 32'h0000_00FF);
  endtask

  task automatic idle_nib(input string tag);
    #42 chk(tag, {28'h0, dq_oe}, 32'h0);
    #8  sclk = 1'b1;
    #50 sclk = 1'b0;
  endtask

  initial begin
    #52;
    chk("rst.dq_oe", {28'h0, dq_oe}, 32'h0);
    chk("rst.dq_out", {28'h0, dq_out}, 32'h0);
    chk("rst.mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst.mem_addr", {8'h0, mem_addr}, 32'h0);
    chk("rst.qe", {31'h0, qe}, 32'h0);
    chk("rst.cont", {31'h0, cont_mode}, 32'h0);
    #48 rst_n = 1'b1;
    #100;

    // WRSR without WREN is ignored; quad read then refused
    cs_lo(); tx_byte(8'h01); tx_byte(8'hFF); tx_byte(8'hFF); cs_hi();
    chk("nowel.qe", {31'h0, qe}, 32'h0);
    cs_lo(); tx_byte(8'hEB);
    for (int i = 0; i < 4; i++) idle_nib("noqe.oe");
    cs_hi();
    chk("noqe.rd", addr_log.size(), 32'h0);

    // boot sequence
    cmd1(8'hFF);
    chk("boot.ff.cont", {31'h0, cont_mode}, 32'h0);
    cmd1(8'hAB);
    cmd1(8'h06);
    cs_lo(); tx_byte(8'h01); tx_byte(8'h02); tx_byte(8'h02); cs_hi();
    chk("boot.qe", {31'h0, qe}, 32'h1);
    addr_log.delete();
    cs_lo(); tx_byte(8'hEB); hdr(24'h000000, 8'hA5);
    chk("boot.cont", {31'h0, cont_mode}, 32'h1);
    rd_byte("boot.b0", 8'h3C);
    cs_hi();
    chk("boot.addr0", log_at(0), 32'h0);
    chk("boot.idle_oe", {28'h0, dq_oe}, 32'h0);

    // continuous read, no opcode
    addr_log.delete();
    cs_lo(); hdr(24'h001234, 8'hA5);
    rd_byte("cont.b0", 8'h11);
    rd_byte("cont.b1", 8'h22);
    rd_byte("cont.b2", 8'h33);
    cs_hi();
    chk("cont.addr0", log_at(0), 32'h001234);
    chk("cont.addr1", log_at(1), 32'h001235);
    chk("cont.addr2", log_at(2), 32'h001236);

    // mode 0x00 drops continuous mode
    cs_lo(); hdr(24'h000000, 8'h00);
    rd_byte("m00.b0", 8'h3C);
    cs_hi();
    chk("m00.cont", {31'h0, cont_mode}, 32'h0);

    // opcode expected again; address wraps
    addr_log.delete();
    cs_lo(); tx_byte(8'hEB); hdr(24'hFFFFFF, 8'hA5);
    rd_byte("wrap.b0", 8'hA7);
    rd_byte("wrap.b1", 8'h3C);
    cs_hi();
    chk("wrap.addr0", log_at(0), 32'hFFFFFF);
    chk("wrap.addr1", log_at(1), 32'h000000);
    chk("wrap.cont", {31'h0, cont_mode}, 32'h1);

    // FF FF address prefix in continuous mode exits it
    cs_lo(); tx_nib(4'hF); tx_nib(4'hF);
    idle_nib("ffx.oe0"); idle_nib("ffx.oe1");
    cs_hi();
    chk("ffx.cont", {31'h0, cont_mode}, 32'h0);

    // cs_n raised after third address nibble, then a clean read aborted mid-data
    cs_lo(); tx_byte(8'hEB); tx_nib(4'h1); tx_nib(4'h2); tx_nib(4'h3);
    cs_n = 1'b1;
    #28 chk("abort.addr.oe", {28'h0, dq_oe}, 32'h0);
    #172;
    addr_log.delete();
    cs_lo(); tx_byte(8'hEB); hdr(24'h001234, 8'h00);
    rd_byte("abort.b0", 8'h11);
    cs_n = 1'b1;
    #28 chk("abort.data.oe", {28'h0, dq_oe}, 32'h0);
    #172;
    chk("abort.addr0", log_at(0), 32'h001234);

    // partial status write leaves SR2 (qe) unchanged; WEL is gone afterwards
    cmd1(8'h06);
    cs_lo(); tx_byte(8'h01); tx_byte(8'h00);
    for (int i = 0; i < 4; i++) tx_nib(4'h0);
    cs_hi();
    chk("srpart.qe", {31'h0, qe}, 32'h1);
    cs_lo(); tx_byte(8'h01); tx_byte(8'h00); tx_byte(8'h00); cs_hi();
    chk("srwel.qe", {31'h0, qe}, 32'h1);

    // reset pulsed mid-data
    cs_lo(); tx_byte(8'hEB); hdr(24'h000000, 8'h00);
    #42 chk("rstd.oe_pre", {28'h0, dq_oe}, 32'hF);
    #8  sclk = 1'b1;
    #50 sclk = 1'b0;
    #10 rst_n = 1'b0;
    #2  chk("rstd.oe", {28'h0, dq_oe}, 32'h0);
    chk("rstd.qe", {31'h0, qe}, 32'h0);
    chk("rstd.cont", {31'h0, cont_mode}, 32'h0);
    #18 rst_n = 1'b1;
    #100 cs_n = 1'b1;
    #100;
    cmd1(8'h06);
    cs_lo(); tx_byte(8'h01); tx_byte(8'h02); tx_byte(8'h02); cs_hi();
    chk("rboot.qe", {31'h0, qe}, 32'h1);
    addr_log.delete();
    cs_lo(); tx_byte(8'hEB); hdr(24'h000000, 8'h00);
    rd_byte("rboot.b0", 8'h3C);
    cs_hi();
    chk("rboot.cont", {31'h0, cont_mode}, 32'h0);
    chk("rboot.addr0", log_at(0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_rom_responder.md
QSPI_ROM_RESPONDER -- requirements
Module: qspi_rom_responder

Interface
REQ-001 SHALL provide port clk, input, 1: system clock; all logic rises on posedge clk.
REQ-002 SHALL provide port rst_n, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL provide port sclk, input, 1: flash serial clock from the host; asynchronous to clk.
REQ-004 SHALL provide port cs_n, input, 1: flash chip select from the host, active-low; asynchronous to clk.
REQ-005 SHALL provide port dq_in, input, 4: host-driven IO0..IO3; IO0 is MOSI in single-line mode.
REQ-006 SHALL provide port dq_out, output, 4: responder-driven IO0..IO3.
REQ-007 SHALL provide port dq_oe, output, 4: per-bit output enable for dq_out, active-high.
REQ-008 SHALL provide port mem_addr, output, 24: byte address of the backing ROM.
REQ-009 SHALL provide port mem_rd, output, 1: one-clk read strobe to the backing ROM.
REQ-010 SHALL provide port mem_data, input, 8: ROM byte, valid on the clk after mem_rd.
REQ-011 SHALL provide port qe, output, 1: quad-enable bit, SR2[1].
REQ-012 SHALL provide port cont_mode, output, 1: continuous-read mode active.

Function
REQ-013 SHALL synchronize sclk, cs_n and dq_in through 2 flops; clk frequency SHALL be at least 4x the sclk frequency.
REQ-014 SHALL detect sclk rise and fall on the synchronized signals; input bits are sampled on rise, outputs change on fall.
REQ-015 SHALL use states IDLE, CMD, SRWR, ADDR, MODE, DUMMY, DATA, IGNORE.
REQ-016 SHALL go to IDLE on synchronized cs_n high from any state, clear bit counters and drive dq_oe=0 within 1 clk; qe and cont_mode are retained.
REQ-017 SHALL leave IDLE on cs_n falling: to ADDR when cont_mode=1, else to CMD.
REQ-018 In CMD, SHALL shift 8 bits from dq_in[0], MSB first.
REQ-019 CMD 0xFF SHALL clear cont_mode and go to IGNORE.
REQ-020 CMD 0xAB SHALL go to IGNORE and have no other effect.
REQ-021 CMD 0x06 SHALL set WEL and go to IGNORE.
REQ-022 CMD 0x01 with WEL=1 SHALL go to SRWR; with WEL=0 it SHALL go to IGNORE.
REQ-023 CMD 0xEB with qe=1 SHALL go to ADDR; with qe=0 it SHALL go to IGNORE.
REQ-024 Any other CMD value SHALL go to IGNORE.
REQ-025 SRWR SHALL shift SR1 (8 bits) then SR2 (8 bits) on dq_in[0]; qe updates after the SR2 bit-0 rise; WEL clears at cs_n high after SRWR.
REQ-026 If cs_n rises before SR2 completes, SR1 and SR2 SHALL be unchanged.
REQ-027 ADDR SHALL take 6 nibbles on dq_in[3:0], most significant first, to form the 24-bit address.
REQ-028 In continuous mode only, if the first two ADDR nibbles are both 4'hF, SHALL clear cont_mode and go to IGNORE.
REQ-029 MODE SHALL take 2 nibbles; at MODE end, cont_mode = (mode[5:4]==2'b10).
REQ-030 DUMMY SHALL count exactly 4 sclk rises; mem_rd pulses on the clk after the first dummy rise with mem_addr = captured address.
REQ-031 DATA SHALL drive the byte high nibble then low nibble, each presented on dq_out with dq_oe=4'hF after an sclk fall and held until the next fall.
REQ-032 The first DATA nibble SHALL be valid from the fall following the 4th dummy rise.
REQ-033 After each low-nibble rise, SHALL increment the address mod 2^24, pulse mem_rd, and latch the next byte before the next fall; reading is unbounded while cs_n stays low.
REQ-034 Outside DATA, dq_oe SHALL be 4'h0 and dq_out SHALL be 4'h0.
REQ-035 Simultaneous sclk rise and cs_n rise in the same synchronized clk SHALL be resolved as cs_n high (edge ignored).
REQ-036 IGNORE SHALL hold until cs_n high.

Reset
REQ-037 While rst_n=0: state=IDLE, dq_out=0, dq_oe=0, mem_rd=0, mem_addr=0, SR1=0, SR2=0, qe=0, WEL=0, cont_mode=0, synchronizers=idle values (cs_n=1, sclk=0).
REQ-038 Reset asserted mid-transaction SHALL abort it; after release the responder SHALL wait for a fresh cs_n fall.

Verification
REQ-039 Host boot sequence 0xFF; 0xAB; 0x06; 0x01,0x02,0x02; 0xEB + addr 000000 + mode A5 + 4 dummy, ROM[0]=0x3C -> qe=1, cont_mode=1, host reads nibbles 3 then C.
REQ-040 With cont_mode=1, cs_n low + addr 001234 + mode A5 + 4 dummy + 3 bytes, ROM[1234..1236]=11,22,33 -> mem_addr 001234..001236, nibbles 1,1,2,2,3,3.
REQ-041 0x01,0xFF,0xFF without a prior 0x06 -> qe stays 0; following 0xEB -> IGNORE, dq_oe stays 0.
REQ-042 Read at FFFFFF for 2 bytes -> mem_addr FFFFFF then 000000.
REQ-043 cs_n raised after the 3rd ADDR nibble, or rst_n pulsed mid-DATA -> dq_oe=0 within 3 clk; next transaction decodes correctly; mode byte 0x00 -> cont_mode=0 and the next transaction expects CMD.
